// File: rtl/acc_cmd_scheduler_if.sv
// acc_cmd_scheduler_if: requester and accelerator signal bundle for the
// command scheduler. The master modport is the scheduler's view; the slave
// modport is the environment's view (requesters plus accelerator).
interface acc_cmd_scheduler_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int CFG_REG_WIDTH = 32
);
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*CFG_REG_WIDTH-1:0] req_funct;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_data;

  // Accelerator side
  logic                             acc_input_valid;
  logic                             acc_input_ready;
  logic [CFG_REG_WIDTH-1:0]         acc_funct;
  logic                             acc_output_valid;
  logic                             acc_output_ready;
  logic [DATA_WIDTH-1:0]            acc_data_out;
  logic                             acc_busy;

  // Status
  logic [GRANT_W-1:0]               grant_id;
  logic                             timeout_err;

  modport master (
    input  req_valid, req_funct, rsp_ready,
    input  acc_input_ready, acc_output_valid, acc_data_out, acc_busy,
    output req_ready, rsp_valid, rsp_data,
    output acc_input_valid, acc_funct, acc_output_ready,
    output grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_funct, rsp_ready,
    output acc_input_ready, acc_output_valid, acc_data_out, acc_busy,
    input  req_ready, rsp_valid, rsp_data,
    input  acc_input_valid, acc_funct, acc_output_ready,
    input  grant_id, timeout_err
  );
endinterface

// File: rtl/acc_cmd_scheduler.sv
// acc_cmd_scheduler: shares one accelerator between NUM_REQ requesters.
// A round-robin arbiter picks one command at a time, issues its latched funct
// word to the accelerator, waits for the result and returns it to the owner.
// Optional feature: define ACC_SCHED_TIMEOUT_EN to enable a response watchdog
// that returns all-ones data and pulses timeout_err after TIMEOUT_CYCLES.
module acc_cmd_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int CFG_REG_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  acc_cmd_scheduler_if.master bus
);

  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("acc_cmd_scheduler: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("acc_cmd_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RETURN
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [GRANT_W-1:0]       last_grant;
  logic [GRANT_W-1:0]       grant_q;
  logic [GRANT_W-1:0]       pick;
  logic [GRANT_W-1:0]       cand;
  logic                     pick_found;
  logic                     grant_now;
  logic [CFG_REG_WIDTH-1:0] funct_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic                     expire;

`ifdef ACC_SCHED_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Counts cycles spent in WAIT_RSP; restarts from zero on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state == WAIT_RSP) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  // A result arriving in the expiry cycle takes precedence over the timeout.
  assign expire = (state == WAIT_RSP) && !bus.acc_output_valid &&
                  (wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = expire;
`else
  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Round-robin search starting one past the previous owner, so the owner
  // that just finished falls to the back of the queue.
  always_comb begin
    pick       = last_grant;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign grant_now = (state == IDLE) && pick_found && !bus.acc_busy;

  // Next-state decode and the handshake outputs, which follow the state.
  always_comb begin
    state_next           = state;
    bus.req_ready        = '0;
    bus.rsp_valid        = '0;
    bus.acc_input_valid  = 1'b0;
    bus.acc_output_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_now) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.acc_input_valid = 1'b1;
        if (bus.acc_input_ready) begin
          bus.req_ready[grant_q] = 1'b1;
          state_next             = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        bus.acc_output_ready = 1'b1;
        if (bus.acc_output_valid || expire) begin
          state_next = RETURN;
        end
      end
      RETURN: begin
        bus.rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, funct and response registers; held stable from ISSUE to RETURN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_W'(NUM_REQ - 1);
      grant_q    <= '0;
      funct_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      if (grant_now) begin
        grant_q <= pick;
        funct_q <= bus.req_funct[int'(pick)*CFG_REG_WIDTH +: CFG_REG_WIDTH];
      end
      if (state == WAIT_RSP) begin
        if (bus.acc_output_valid) begin
          rsp_data_q <= bus.acc_data_out;
        end else if (expire) begin
          rsp_data_q <= '1;
        end
      end
      if (state == RETURN && bus.rsp_ready[grant_q]) begin
        last_grant <= grant_q;
      end
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.acc_funct = funct_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_acc_cmd_scheduler.sv
// tb_acc_cmd_scheduler: scoreboard bench for acc_cmd_scheduler. Expected
// responses are queued as requests are driven and popped on each response
// handshake. A small accelerator model answers funct*3 after respDelay cycles.
module tb_acc_cmd_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int DATA_WIDTH     = 64;
  localparam int CFG_REG_WIDTH  = 32;
  localparam int TIMEOUT_CYCLES = 16;

  typedef struct packed {
    logic [1:0]            id;
    logic [DATA_WIDTH-1:0] data;
  } expect_t;

  logic clock;
  logic reset;

  acc_cmd_scheduler_if #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DATA_WIDTH),
    .CFG_REG_WIDTH(CFG_REG_WIDTH)
  ) bus ();

  acc_cmd_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .DATA_WIDTH    (DATA_WIDTH),
    .CFG_REG_WIDTH (CFG_REG_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int                       numCompared = 0;
  int                       numMismatched = 0;
  int                       rspCount = 0;
  int                       reqReadyPulses [NUM_REQ];
  expect_t                  expectQ [$];
  logic                     autoDrop;
  logic                     accHang;
  int                       respDelay;
  logic [CFG_REG_WIDTH-1:0] functTable [NUM_REQ];

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] expData(input int id);
    return 64'(functTable[id]) * 64'd3;
  endfunction

  task automatic pushExpect(input int id, input logic [DATA_WIDTH-1:0] data);
    expect_t e;
    e.id   = 2'(id);
    e.data = data;
    expectQ.push_back(e);
  endtask

  // Raises the valid bits of the requesters in mask (called at a negedge)
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    bus.req_valid = bus.req_valid | mask;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 0);
    checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
    checkOutput({tag, "_rsp_data"}, bus.rsp_data, 0);
    checkOutput({tag, "_acc_input_valid"}, 64'(bus.acc_input_valid), 0);
    checkOutput({tag, "_acc_funct"}, 64'(bus.acc_funct), 0);
    checkOutput({tag, "_acc_output_ready"}, 64'(bus.acc_output_ready), 0);
    checkOutput({tag, "_grant_id"}, 64'(bus.grant_id), 0);
    checkOutput({tag, "_timeout_err"}, 64'(bus.timeout_err), 0);
  endtask

  task automatic applyReset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checkResetOutputs(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at negedge+2 once target responses were seen, or after budget cycles
  task automatic waitResponses(input int target, input int budget, input string tag);
    int cycles;
    cycles = 0;
    while (rspCount < target && cycles < budget) begin
      @(negedge clock);
      #2;
      cycles++;
    end
    checkOutput(tag, 64'(rspCount), 64'(target));
  endtask

  // Waits until the scheduler is in WAIT_RSP (acc_output_ready seen), bounded
  task automatic waitForWait(input string tag);
    int cycles;
    cycles = 0;
    do begin
      @(negedge clock);
      #1;
      cycles++;
    end while (!bus.acc_output_ready && cycles < 50);
    checkOutput(tag, 64'(bus.acc_output_ready), 1);
  endtask

  // Accelerator model: accepts a command, then answers funct*3 after respDelay
  initial begin : accModel
    int                       waitCnt;
    logic                     pending;
    logic [CFG_REG_WIDTH-1:0] cmd;
    waitCnt = 0;
    pending = 1'b0;
    cmd     = '0;
    forever begin
      @(negedge clock);
      bus.acc_input_ready  = 1'b0;
      bus.acc_output_valid = 1'b0;
      if (reset) begin
        pending = 1'b0;
      end else if (pending) begin
        if (!accHang && waitCnt >= respDelay) begin
          bus.acc_output_valid = 1'b1;
          bus.acc_data_out     = 64'(cmd) * 64'd3;
          pending              = 1'b0;
        end else begin
          waitCnt++;
        end
      end else if (bus.acc_input_valid) begin
        bus.acc_input_ready = 1'b1;
        cmd                 = bus.acc_funct;
        pending             = 1'b1;
        waitCnt             = 0;
      end
    end
  end

  // Monitor: one-hot checks, req_ready accounting and scoreboard pops
  initial begin : monitor
    expect_t expItem;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (bus.req_ready != '0) begin
          checkOutput("req_ready_onehot", 64'($onehot(bus.req_ready)), 1);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
              reqReadyPulses[i]++;
              if (autoDrop) bus.req_valid[i] = 1'b0;
            end
          end
        end
        if (bus.rsp_valid != '0) begin
          checkOutput("rsp_valid_onehot", 64'($onehot(bus.rsp_valid)), 1);
          if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
            if (expectQ.size() == 0) begin
              checkOutput("unexpected_rsp", 64'(bus.rsp_valid), 0);
            end else begin
              expItem = expectQ.pop_front();
              checkOutput("rsp_owner", 64'(bus.rsp_valid), 64'(1 << expItem.id));
              checkOutput("rsp_grant_id", 64'(bus.grant_id), 64'(expItem.id));
              checkOutput("rsp_data", bus.rsp_data, expItem.data);
            end
            rspCount++;
          end
        end
      end
    end
  end

  // Global runaway guard
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL global_timeout: got %0d responses, expected the run to end", rspCount);
    $fatal(1, "[TB] simulation did not finish");
  end

  // Main test sequence
  initial begin : main
    int base;
    logic seen;
    int waitCycle;
    reset         = 1'b1;
    autoDrop      = 1'b1;
    accHang       = 1'b0;
    respDelay     = 0;
    functTable[0] = 32'd2;
    functTable[1] = 32'h11;
    functTable[2] = 32'h25;
    functTable[3] = 32'h3A;
    for (int i = 0; i < NUM_REQ; i++) reqReadyPulses[i] = 0;
    bus.req_valid        = '0;
    bus.rsp_ready        = '1;
    bus.acc_input_ready  = 1'b0;
    bus.acc_output_valid = 1'b0;
    bus.acc_data_out     = '0;
    bus.acc_busy         = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_funct[i*CFG_REG_WIDTH +: CFG_REG_WIDTH] = functTable[i];

    $display("[TB] reset values");
    applyReset("rst");

    $display("[TB] single request, slow accelerator");
    respDelay = 500;
    @(negedge clock);
    pushExpect(0, 64'h6);
    applyStimulus(4'b0001);
    waitResponses(1, 700, "t1_done");
    repeat (3) @(negedge clock);
    checkOutput("t1_req_ready_pulses", 64'(reqReadyPulses[0]), 1);

    $display("[TB] all requesters held, round-robin order");
    applyReset("rst2");
    autoDrop  = 1'b0;
    respDelay = 2;
    base      = rspCount;
    @(negedge clock);
    pushExpect(0, expData(0));
    pushExpect(1, expData(1));
    pushExpect(2, expData(2));
    pushExpect(3, expData(3));
    pushExpect(0, expData(0));
    applyStimulus(4'b1111);
    waitResponses(base + 5, 200, "t2_done");
    bus.req_valid = '0;
    autoDrop      = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("t2_no_extra_issue", 64'(bus.acc_input_valid), 0);

    $display("[TB] accelerator busy blocks grants");
    base         = rspCount;
    respDelay    = 1;
    @(negedge clock);
    bus.acc_busy = 1'b1;
    pushExpect(2, expData(2));
    applyStimulus(4'b0100);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      #1;
      checkOutput("t3_busy_no_issue", 64'(bus.acc_input_valid), 0);
    end
    @(negedge clock);
    bus.acc_busy = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("t3_issue_latency", 64'(bus.acc_input_valid), 1);
    checkOutput("t3_grant_id", 64'(bus.grant_id), 2);
    checkOutput("t3_acc_funct", 64'(bus.acc_funct), 64'(functTable[2]));
    waitResponses(base + 1, 50, "t3_done");

    $display("[TB] response held in RETURN");
    base = rspCount;
    @(negedge clock);
    bus.rsp_ready = '0;
    pushExpect(1, expData(1));
    applyStimulus(4'b0010);
    waitCycle = 0;
    do begin
      @(negedge clock);
      #1;
      waitCycle++;
    end while (bus.rsp_valid == '0 && waitCycle < 50);
    checkOutput("t4_reach_return", 64'(bus.rsp_valid), 64'h2);
    @(negedge clock);
    pushExpect(3, expData(3));
    applyStimulus(4'b1000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      checkOutput("t4_hold_rsp_valid", 64'(bus.rsp_valid), 64'h2);
      checkOutput("t4_hold_rsp_data", bus.rsp_data, expData(1));
      checkOutput("t4_hold_no_grant", 64'(bus.acc_input_valid), 0);
    end
    @(negedge clock);
    bus.rsp_ready = '1;
    waitResponses(base + 2, 60, "t4_done");

    $display("[TB] no accelerator result");
    base    = rspCount;
    accHang = 1'b1;
    @(negedge clock);
`ifdef ACC_SCHED_TIMEOUT_EN
    pushExpect(0, '1);
    applyStimulus(4'b0001);
    waitForWait("t5_reach_wait");
    waitCycle = 1;
    seen      = 1'b0;
    while (!seen && waitCycle < 40) begin
      if (bus.timeout_err) begin
        seen = 1'b1;
      end else begin
        @(negedge clock);
        #1;
        waitCycle++;
      end
    end
    checkOutput("t5_timeout_cycle", 64'(waitCycle), 64'(TIMEOUT_CYCLES));
    @(negedge clock);
    #1;
    checkOutput("t5_timeout_pulse_len", 64'(bus.timeout_err), 0);
    waitResponses(base + 1, 20, "t5_done");
    accHang = 1'b0;
    repeat (3) @(negedge clock);
`else
    pushExpect(0, expData(0));
    applyStimulus(4'b0001);
    waitForWait("t5_reach_wait");
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      #1;
      if (bus.timeout_err) seen = 1'b1;
    end
    checkOutput("t5_no_timeout_err", 64'(seen), 0);
    checkOutput("t5_still_waiting", 64'(bus.acc_output_ready), 1);
    accHang = 1'b0;
    waitResponses(base + 1, 20, "t5_done");
`endif

    $display("[TB] reset during WAIT_RSP");
    base    = rspCount;
    accHang = 1'b1;
    @(negedge clock);
    applyStimulus(4'b0001);
    waitForWait("t6_reach_wait");
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkResetOutputs("t6_rst");
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b0;
    accHang = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("t6_no_rsp_after_abort", 64'(rspCount), 64'(base));
    pushExpect(0, expData(0));
    applyStimulus(4'b0001);
    waitResponses(base + 1, 50, "t6_done");

    repeat (5) @(negedge clock);
    checkOutput("sb_empty", 64'(expectQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
